// File: rtl/noc_pkg.sv
// Shared types, constants and the destination-to-port routing helper for the
// four-port byte-serial router.
package noc_pkg;

    localparam int NUM_PORTS     = 4;
    localparam int BYTES_PER_PKT = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_RECV = 2'd1,
        IN_HOLD = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_READY = 2'd1,
        OUT_SEND  = 2'd2
    } out_state_e;

    // Two map bits per destination ID, destination 0 in the LSBs.
    function automatic logic [1:0] route(input logic [3:0] dest, input logic [31:0] map);
        return map[{dest, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: the search starts at i_ptr and wraps upward;
// o_next_ptr is the slot just after the winner.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    input  logic       i_en,
    output logic [3:0] o_gnt,
    output logic [1:0] o_next_ptr
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        w_idx      = i_ptr;
        w_found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = i_ptr + 2'(k);
            if (i_en && !w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_next_ptr   = w_idx + 2'd1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_router.sv
// Four-port byte-serial NoC router: per-port deserialiser, destination routing,
// per-output round-robin arbitration and re-serialisation.
module noc_router
    import noc_pkg::*;
#(
    parameter int          ROUTERID = 0,
    parameter logic [31:0] PORT_MAP = 32'hFFFF_FFE4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [3:0]      put_inbound,
    input  logic [3:0][7:0] payload_inbound,
    output logic [3:0]      free_inbound,
    output logic [3:0]      put_outbound,
    output logic [3:0][7:0] payload_outbound,
    input  logic [3:0]      free_outbound
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PKT - 1);

    in_state_e            r_in_state [NUM_PORTS];
    in_state_e            w_in_next  [NUM_PORTS];
    logic [1:0]           r_in_cnt   [NUM_PORTS];
    pkt_t                 r_in_pkt   [NUM_PORTS];
    logic [1:0]           w_route    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_in_take;
    logic [NUM_PORTS-1:0] w_in_gnt;

    out_state_e           r_out_state [NUM_PORTS];
    out_state_e           w_out_next  [NUM_PORTS];
    logic [1:0]           r_out_cnt   [NUM_PORTS];
    logic [31:0]          r_out_data  [NUM_PORTS];
    logic [31:0]          w_out_load  [NUM_PORTS];
    logic [1:0]           r_ptr       [NUM_PORTS];
    logic [1:0]           w_next_ptr  [NUM_PORTS];
    logic [3:0]           w_req       [NUM_PORTS];
    logic [3:0]           w_gnt       [NUM_PORTS];

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_req[o] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_route[i]      = route(r_in_pkt[i].dest, PORT_MAP);
            free_inbound[i] = (r_in_state[i] == IN_IDLE);
            w_in_take[i]    = put_inbound[i] && (r_in_state[i] != IN_HOLD);
            for (int o = 0; o < NUM_PORTS; o++) begin
                w_req[o][i] = (r_in_state[i] == IN_HOLD) && (w_route[i] == 2'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter4 u_arb (
            .i_req      (w_req[o]),
            .i_ptr      (r_ptr[o]),
            .i_en       (r_out_state[o] == OUT_EMPTY),
            .o_gnt      (w_gnt[o]),
            .o_next_ptr (w_next_ptr[o])
        );
    end

    // An input routes to exactly one output, so at most one grant per input.
    always_comb begin
        w_in_gnt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_out_load[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_gnt[o][i]) begin
                    w_in_gnt[i]   = 1'b1;
                    w_out_load[o] = r_in_pkt[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_in_next[i] = r_in_state[i];
            case (r_in_state[i])
                IN_IDLE: if (put_inbound[i]) w_in_next[i] = IN_RECV;
                IN_RECV: if (put_inbound[i] && r_in_cnt[i] == LAST_BYTE) w_in_next[i] = IN_HOLD;
                IN_HOLD: if (w_in_gnt[i]) w_in_next[i] = IN_IDLE;
                default: w_in_next[i] = IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_in_state[i] <= IN_IDLE;
                r_in_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_in_state[i] <= w_in_next[i];
                if (w_in_take[i]) r_in_cnt[i] <= r_in_cnt[i] + 2'd1;
            end
        end
    end

    // Bytes arrive MSB first; the counter wraps to 0 after the last byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_in_take[i]) r_in_pkt[i][{~r_in_cnt[i], 3'b000} +: 8] <= payload_inbound[i];
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_out_next[o]       = r_out_state[o];
            put_outbound[o]     = 1'b0;
            payload_outbound[o] = '0;
            case (r_out_state[o])
                OUT_EMPTY: if (|w_gnt[o]) w_out_next[o] = OUT_READY;
                OUT_READY: begin
                    if (free_outbound[o]) begin
                        put_outbound[o] = 1'b1;
                        w_out_next[o]   = OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    put_outbound[o] = 1'b1;
                    if (r_out_cnt[o] == LAST_BYTE) w_out_next[o] = OUT_EMPTY;
                end
                default: w_out_next[o] = OUT_EMPTY;
            endcase
            if (put_outbound[o]) begin
                payload_outbound[o] = r_out_data[o][{~r_out_cnt[o], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_out_state[o] <= OUT_EMPTY;
                r_out_cnt[o]   <= '0;
                r_ptr[o]       <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_out_state[o] <= w_out_next[o];
                if (put_outbound[o]) r_out_cnt[o] <= r_out_cnt[o] + 2'd1;
                if (|w_gnt[o])       r_ptr[o]     <= w_next_ptr[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (|w_gnt[o]) r_out_data[o] <= w_out_load[o];
        end
    end

endmodule

// File: tb/tb_noc_router.sv
// Scoreboard bench for noc_router: senders push expected packets per (output, source)
// flow; a negedge monitor reassembles outbound bytes and compares.
module tb_noc_router;

    localparam logic [31:0] MAP   = 32'hFFFF_FFE4;
    localparam int          BOUND = 4000;
    localparam int          NRAND = 30;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [3:0]      put_inbound;
    logic [3:0][7:0] payload_inbound;
    logic [3:0]      free_inbound;
    logic [3:0]      put_outbound;
    logic [3:0][7:0] payload_outbound;
    logic [3:0]      free_outbound;

    always #5 clk = ~clk;

    noc_router #(.ROUTERID(0), .PORT_MAP(MAP)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .free_inbound     (free_inbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_outbound    (free_outbound)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] exp_q   [4][4][$];
    logic [31:0] arr_word[4][$];
    int          arr_gap [4][$];
    int          b0cyc[4];
    int          b3cyc[4];
    int          ocnt[4];
    int          irun[4];
    logic [31:0] obuf[4];
    logic        rnd_on = 1'b0;
    logic [31:0] cexp[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference routing: two map bits per destination ID.
    function automatic int mdl_route(input logic [3:0] d);
        logic [31:0] t;
        t = MAP >> (2 * d);
        return int'(t & 32'd3);
    endfunction

    function automatic bit all_drained();
        for (int o = 0; o < 4; o++) begin
            if (ocnt[o] != 0) return 1'b0;
            for (int s = 0; s < 4; s++) if (exp_q[o][s].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic score(input int o, input logic [31:0] w);
        int s;
        s = int'(w[31:28]);
        if (s > 3) begin
            check($sformatf("out%0d_src_field", o), w[31:28], 4'd0);
        end else if (exp_q[o][s].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out%0d_unexpected: got %h, expected no packet", o, w);
        end else begin
            check($sformatf("out%0d_pkt_from%0d", o, s), w, exp_q[o][s].pop_front());
        end
    endtask

    always @(negedge clk) begin
        for (int o = 0; o < 4; o++) begin
            if (!rst_b) begin
                ocnt[o] = 0;
                irun[o] = 0;
            end else begin
                if (put_outbound[o]) begin
                    if (ocnt[o] == 0) begin
                        b0cyc[o] = cyc;
                        arr_gap[o].push_back(cyc - b3cyc[o]);
                    end
                    obuf[o] = {obuf[o][23:0], payload_outbound[o]};
                    ocnt[o]++;
                    if (ocnt[o] == 4) begin
                        ocnt[o]  = 0;
                        b3cyc[o] = cyc;
                        arr_word[o].push_back(obuf[o]);
                        score(o, obuf[o]);
                    end
                end else begin
                    check($sformatf("out%0d_idle_payload", o), 32'(payload_outbound[o]), 32'd0);
                    if (ocnt[o] != 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL out%0d_put_gap: got gap after %0d bytes, expected 4 consecutive", o, ocnt[o]);
                        ocnt[o] = 0;
                    end
                end
                if (put_inbound[o]) begin
                    irun[o]++;
                    if (irun[o] == 4) begin
                        irun[o] = 0;
                        n_cmp++;
                    end
                end else if (irun[o] != 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL in%0d_proto: got put drop after %0d bytes, expected 4", o, irun[o]);
                    irun[o] = 0;
                end
            end
        end
    end

    task automatic send_pkt(input int p, input logic [31:0] pkt);
        int k;
        exp_q[mdl_route(pkt[27:24])][p].push_back(pkt);
        k = 0;
        while (!free_inbound[p]) begin
            tick();
            k++;
            if (k > BOUND) begin
                check($sformatf("in%0d_free_timeout", p), 32'd0, 32'd1);
                return;
            end
        end
        for (int b = 0; b < 4; b++) begin
            put_inbound[p]     = 1'b1;
            payload_inbound[p] = pkt[31 - 8*b -: 8];
            tick();
            check($sformatf("in%0d_free_low_b%0d", p, b), 32'(free_inbound[p]), 32'd0);
        end
        put_inbound[p]     = 1'b0;
        payload_inbound[p] = '0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (!all_drained() && k <= BOUND) begin
            tick();
            k++;
        end
        check("drain_in_time", 32'(k > BOUND), 32'd0);
    endtask

    task automatic rand_sender(input int p);
        logic [31:0] pk;
        for (int n = 0; n < NRAND; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            pk = {4'(p), 4'($urandom_range(0, 15)), 24'($urandom)};
            send_pkt(p, pk);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_b           = 1'b0;
        put_inbound     = '0;
        payload_inbound = '0;
        free_outbound   = 4'hF;
        repeat (3) tick();
        check("reset_free_inbound", 32'(free_inbound), 32'hF);
        check("reset_put_outbound", 32'(put_outbound), 32'h0);
        check("reset_payload_outbound", payload_outbound, 32'h0);
        rst_b = 1'b1;
        tick();

        // Basic delivery with exact latency
        send_pkt(0, 32'h02ABCDEF);
        check("basic_free_still_low", 32'(free_inbound[0]), 32'd0);
        tick();
        check("basic_free_rise", 32'(free_inbound[0]), 32'd1);
        check("basic_put_b0", 32'(put_outbound[2]), 32'd1);
        check("basic_byte0", 32'(payload_outbound[2]), 32'h02);
        tick();
        check("basic_byte1", 32'(payload_outbound[2]), 32'hAB);
        tick();
        check("basic_byte2", 32'(payload_outbound[2]), 32'hCD);
        tick();
        check("basic_byte3", 32'(payload_outbound[2]), 32'hEF);
        check("basic_put_b3", 32'(put_outbound[2]), 32'd1);
        wait_drain();

        // Back-pressure: output 2 withheld
        free_outbound[2] = 1'b0;
        send_pkt(0, 32'h02000001);
        send_pkt(0, 32'h02000002);
        fork
            send_pkt(0, 32'h02000003);
        join_none
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_no_put", 32'(put_outbound[2]), 32'd0);
            check("bp_free_low", 32'(free_inbound[0]), 32'd0);
        end
        free_outbound[2] = 1'b1;
        wait_drain();

        // Reset in the middle of an inbound packet
        put_inbound[0]     = 1'b1;
        payload_inbound[0] = 8'h03;
        tick();
        payload_inbound[0] = 8'hCA;
        tick();
        put_inbound[0]     = 1'b0;
        payload_inbound[0] = '0;
        rst_b              = 1'b0;
        #1;
        check("midrst_free", 32'(free_inbound), 32'hF);
        check("midrst_put", 32'(put_outbound), 32'h0);
        tick();
        tick();
        check("midrst_put_held", 32'(put_outbound), 32'h0);
        rst_b = 1'b1;
        tick();
        send_pkt(0, 32'h03CAFE00);
        wait_drain();
        check("midrst_last_word", arr_word[3][$], 32'h03CAFE00);

        // Contention on output 2, then a fairness pair
        arr_word[2].delete();
        arr_gap[2].delete();
        fork
            send_pkt(0, 32'h0200000A);
            send_pkt(1, 32'h1200000B);
            send_pkt(3, 32'h3200000C);
        join
        k = 0;
        while (free_inbound[1:0] != 2'b11 && k <= BOUND) begin
            tick();
            k++;
        end
        check("cont_inputs_free", 32'(k > BOUND), 32'd0);
        fork
            send_pkt(0, 32'h0200000D);
            send_pkt(1, 32'h1200000E);
        join
        wait_drain();
        cexp = '{32'h0200000A, 32'h1200000B, 32'h3200000C, 32'h0200000D, 32'h1200000E};
        check("cont_count", 32'(arr_word[2].size()), 32'd5);
        if (arr_word[2].size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                check($sformatf("cont_order%0d", j), arr_word[2][j], cexp[j]);
                if (j > 0) check($sformatf("cont_gap%0d", j), 32'(arr_gap[2][j]), 32'd2);
            end
        end

        // Parallel traffic on two outputs
        fork
            send_pkt(0, 32'h01000011);
            send_pkt(1, 32'h10000022);
        join
        wait_drain();
        check("par_word1", arr_word[1][$], 32'h01000011);
        check("par_word0", arr_word[0][$], 32'h10000022);
        check("par_same_cycle", 32'(b0cyc[1]), 32'(b0cyc[0]));

        // Destination outside 0..3 goes to port 3
        send_pkt(1, 32'h19123456);
        wait_drain();
        check("defmap_port3", arr_word[3][$], 32'h19123456);

        // Randomized traffic with random output back-pressure
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                free_outbound = 4'($urandom);
                tick();
            end
        join_none
        fork
            rand_sender(0);
            rand_sender(1);
            rand_sender(2);
            rand_sender(3);
        join
        rnd_on = 1'b0;
        tick();
        tick();
        free_outbound = 4'hF;
        wait_drain();

        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 4; s++) begin
                check($sformatf("leftover_out%0d_src%0d", o, s), 32'(exp_q[o][s].size()), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
